// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding and
// parameter defaults.
package mem_bus_arbiter_pkg;

  localparam int DEFAULT_NUM_MASTERS    = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWNED   = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_picker.sv
// Round-robin priority picker: selects the first requester at or after
// rr_ptr, wrapping from N-1 back to 0.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] index,
  output logic          any
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(rr_ptr) + k) % N);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        index       = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin memory bus arbiter (IDLE -> OWNED -> RELEASE). Define
// MEM_ARB_TIMEOUT_EN to enable the ownership watchdog and timeout_err pulse.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = DEFAULT_NUM_MASTERS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int IW             = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] done,
  input  logic                   mem_data_valid,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IW-1:0]          owner,
  output logic                   bus_busy,
  output logic                   timeout_err,
  output arb_state_e             state
);

  // Handshake: req is a level held until grant or withdrawal; the owner
  // ends its tenure with a one-cycle done pulse or by dropping req. done
  // from anyone but the current owner, or outside OWNED, is ignored.

  logic [IW-1:0]          rr_ptr;
  logic [NUM_MASTERS-1:0] pick_winner;
  logic [IW-1:0]          pick_index;
  logic                   pick_any;
  logic                   owner_release;
  logic                   tmo_hit;

  rr_priority_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_winner),
    .index  (pick_index),
    .any    (pick_any)
  );

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    if (int'(i) == NUM_MASTERS - 1) return '0;
    else return i + IW'(1);
  endfunction

  assign owner_release = done[owner] | ~req[owner];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_count;

  // Counts completed owned cycles without a response beat; the release
  // fires on the edge that closes the TIMEOUT_CYCLES-th such cycle.
  assign tmo_hit = !mem_data_valid && (tmo_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_count <= '0;
    end else if (state == IDLE && pick_any) begin
      tmo_count <= '0;
    end else if (state == OWNED) begin
      if (mem_data_valid) tmo_count <= '0;
      else                tmo_count <= tmo_count + CW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = mem_data_valid | (TIMEOUT_CYCLES < 1);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= OWNED;
            grant    <= pick_winner;
            owner    <= pick_index;
            rr_ptr   <= next_ptr(pick_index);
            bus_busy <= 1'b1;
          end
        end
        OWNED: begin
          // A normal release wins over a coincident watchdog expiry.
          if (owner_release || tmo_hit) begin
            state       <= RELEASE;
            grant       <= '0;
            owner       <= '0;
            timeout_err <= tmo_hit && !owner_release;
          end
        end
        RELEASE: begin
          state    <= IDLE;
          bus_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          owner    <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios plus randomized
// request traffic checked against a round-robin reference model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic          mem_data_valid;
  logic [N-1:0]  grant;
  logic [IW-1:0] owner;
  logic          bus_busy;
  logic          timeout_err;
  arb_state_e    state;

  int errors = 0;
  int checks = 0;
  logic [IW-1:0] exp_q[$];
  int model_ptr = 0;

  mem_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .done           (done),
    .mem_data_valid (mem_data_valid),
    .grant          (grant),
    .owner          (owner),
    .bus_busy       (bus_busy),
    .timeout_err    (timeout_err),
    .state          (state)
  );

  // ---------------- clock / time limit ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL time_limit: got running expected finished");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference arbitration rule: first requester scanning upward from ptr.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic void expect_grant(input logic [N-1:0] r);
    int w;
    w = model_pick(r, model_ptr);
    model_ptr = (w + 1) % N;
    exp_q.push_back(IW'(w));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output int waited);
    waited = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        waited = k;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL grant_wait: got no grant expected grant within 20 cycles");
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = '0;
    done = '0;
    model_ptr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One bus tenure: predict the winner, wait for it, hold, then release.
  task automatic run_txn(input int hold, input bit by_done, input bit stray, output int waited);
    int w;
    w = model_pick(req, model_ptr);
    expect_grant(req);
    wait_grant(waited);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      done = '0;
      mem_data_valid = 1'($urandom_range(0, 1));
      if (stray && i == 0) done[(w + 2) % N] = 1'b1;
    end
    @(negedge clk);
    done = '0;
    if (by_done) done[w] = 1'b1;
    else req[w] = 1'b0;
    @(negedge clk);
    done = '0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [N-1:0]  prev;
    logic [IW-1:0] w;
    int            zero_run;
    prev = '0;
    zero_run = 99;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("grant_in_reset", 32'(grant), 0);
        prev = '0;
        zero_run = 99;
        continue;
      end
      check("onehot", 32'($countones(grant) <= 1), 1);
      if (grant == '0) begin
        zero_run++;
        check("owner_no_grant", 32'(owner), 0);
        check("busy_no_grant", 32'(bus_busy), 32'(zero_run == 1));
      end else begin
        check("busy_owned", 32'(bus_busy), 1);
        if (prev == '0) begin
          check("turnaround_gap", 32'(zero_run >= 2), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got %0d expected none", owner);
          end else begin
            w = exp_q.pop_front();
            check("grant_owner", 32'(owner), 32'(w));
            check("grant_vector", 32'(grant), 32'(N'(1) << w));
          end
        end else begin
          check("grant_hold", 32'(grant), 32'(prev));
        end
        zero_run = 0;
      end
`ifndef MEM_ARB_TIMEOUT_EN
      check("timeout_err_low", 32'(timeout_err), 0);
`endif
      prev = grant;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int waited;
    int cnt;
    reset = 1'b1;
    req = '0;
    done = '0;
    mem_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_busy", 32'(bus_busy), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_state", 32'(state), 32'(IDLE));
    reset = 1'b0;

    // single requester
    @(negedge clk);
    req = 4'b0100;
    run_txn(3, 1'b1, 1'b0, waited);
    check("single_latency", 32'(waited), 1);
    check("single_release", 32'(state), 32'(RELEASE));
    check("single_release_busy", 32'(bus_busy), 1);
    req = '0;
    @(negedge clk);
    check("single_idle", 32'(state), 32'(IDLE));
    check("single_idle_busy", 32'(bus_busy), 0);

    // full contention: expected order 0,1,2,3,0
    apply_reset();
    req = 4'b1111;
    repeat (5) run_txn(3, 1'b1, 1'b0, waited);
    req = '0;

    // wrap: grant 2 leaves the pointer at 3, then 0101 must pick 0
    apply_reset();
    req = 4'b0100;
    run_txn(2, 1'b1, 1'b0, waited);
    req = 4'b0101;
    run_txn(2, 1'b1, 1'b0, waited);
    req = '0;

    // abort by withdrawing req, with a stray done from master 3
    apply_reset();
    req = 4'b0010;
    run_txn(4, 1'b0, 1'b1, waited);
    check("abort_release", 32'(state), 32'(RELEASE));
    req = '0;

    // watchdog
    apply_reset();
    mem_data_valid = 1'b0;
    req = 4'b0001;
    expect_grant(req);
    wait_grant(waited);
`ifdef MEM_ARB_TIMEOUT_EN
    cnt = 1;
    for (int k = 0; k < 40 && grant != '0; k++) begin
      @(negedge clk);
      if (grant != '0) cnt++;
    end
    check("timeout_owned_cycles", 32'(cnt), TMO);
    check("timeout_pulse", 32'(timeout_err), 1);
    req = '0;
    @(negedge clk);
    check("timeout_pulse_end", 32'(timeout_err), 0);
`else
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (grant == 4'b0001) cnt++;
    end
    check("no_watchdog_hold", 32'(cnt), 30);
    check("no_watchdog_err", 32'(timeout_err), 0);
    done[0] = 1'b1;
    @(negedge clk);
    done = '0;
    req = '0;
`endif

    // asynchronous reset while master 2 owns the bus
    apply_reset();
    req = 4'b0100;
    expect_grant(req);
    wait_grant(waited);
    #2 reset = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant), 0);
    check("async_rst_owner", 32'(owner), 0);
    check("async_rst_busy", 32'(bus_busy), 0);
    check("async_rst_state", 32'(state), 32'(IDLE));
    model_ptr = 0;
    req = 4'b0110;
    @(negedge clk);
    reset = 1'b0;
    run_txn(2, 1'b1, 1'b0, waited);
    req = '0;

    // randomized traffic
    apply_reset();
    req = N'($urandom_range(1, 15));
    repeat (40) begin
      run_txn($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), waited);
      req = N'($urandom_range(1, 15));
    end
    req = '0;
    mem_data_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of bus masters sharing the memory bus (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 64, owned cycles allowed without mem_data_valid before forced release.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  NUM_MASTERS  per-master bus request, level, held until granted or withdrawn.
REQ-006 Port done  input  NUM_MASTERS  per-master release strobe, one cycle, valid only from current owner.
REQ-007 Port mem_data_valid  input  1  memory response beat, shared bus.
REQ-008 Port grant  output  NUM_MASTERS  one-hot or zero bus grant, registered.
REQ-009 Port owner  output  clog2(NUM_MASTERS)  index of granted master; 0 when no grant.
REQ-010 Port bus_busy  output  1  high whenever the FSM is not IDLE.
REQ-011 Port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-012 FSM states SHALL be IDLE, OWNED, RELEASE.
REQ-013 IDLE: if any req bit high at edge t, SHALL assert grant for the winner from edge t (visible cycle t+1) and enter OWNED; else stay IDLE with grant=0.
REQ-014 Winner SHALL be the first requesting index at or after rr_ptr, wrapping from NUM_MASTERS-1 to 0.
REQ-015 On each grant, rr_ptr SHALL load (winner+1) mod NUM_MASTERS; rr_ptr unchanged otherwise.
REQ-016 OWNED: grant and owner SHALL hold constant; done[owner]=1 or req[owner]=0 SHALL move to RELEASE next edge.
REQ-017 done bits of non-owners SHALL be ignored in all states; done in IDLE/RELEASE ignored.
REQ-018 RELEASE: grant SHALL be 0, bus_busy 1, for exactly one dead cycle; then IDLE.
REQ-019 Minimum turnaround owner-to-next-owner SHALL be 2 cycles of zero grant (RELEASE, then IDLE arbitration edge).
REQ-020 At most one grant bit SHALL ever be high; grant SHALL never change within OWNED.
REQ-021 Simultaneous done[owner] and timeout expiry SHALL be treated as normal release, timeout_err stays 0.

Reset
REQ-022 reset high SHALL asynchronously force state IDLE, grant 0, owner 0, bus_busy 0, timeout_err 0, rr_ptr 0, timeout counter 0.
REQ-023 Reset asserted during OWNED SHALL drop grant without passing RELEASE; first arbitration after deassertion starts at index 0.

Configuration
REQ-024 Macro MEM_ARB_TIMEOUT_EN SHALL gate the watchdog.
REQ-025 Defined: counter clears on entering OWNED and on each mem_data_valid, increments each OWNED cycle; at TIMEOUT_CYCLES SHALL force RELEASE and pulse timeout_err with the transition.
REQ-026 Undefined: no counter logic; timeout_err tied 0; OWNED exits only per REQ-016.

Structure
REQ-027 Shared package SHALL hold the state encoding (IDLE=2'b00, OWNED=2'b01, RELEASE=2'b10), NUM_MASTERS and TIMEOUT_CYCLES defaults.
REQ-028 Round-robin selection SHALL be a sub-module rr_priority_picker (inputs req, rr_ptr; outputs one-hot winner, index, any).
REQ-029 State, grant, owner, rr_ptr SHALL be flip-flops; grant SHALL NOT be combinational from req.

Verification
REQ-030 Single: req=4'b0100 from IDLE -> grant=4'b0100, owner=2 next cycle; done[2] -> RELEASE one cycle, then IDLE, bus_busy low.
REQ-031 Contention: req=4'b1111 held, each owner pulses done after 3 cycles -> grant order 0,1,2,3,0 with 2 zero-grant cycles between.
REQ-032 Wrap: rr_ptr=3 (after granting 2), req=4'b0101 -> grant master 0.
REQ-033 Abort/stray done: owner 1 drops req mid-OWNED -> RELEASE next edge; done[3] while 1 owns -> no effect.
REQ-034 Timeout (macro defined, TIMEOUT_CYCLES=8): owner never sees mem_data_valid -> forced RELEASE on 8th owned cycle, timeout_err one pulse; macro undefined -> grant held indefinitely.
REQ-035 Reset mid-OWNED for master 2 -> grant=0 same cycle asynchronously; after release with req=4'b0110 -> master 1 granted.
